muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the EXE stage; executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Drives the EXE completion condition: EXE_over = EXE_valid & (~mul_or_div | md_done).
- Holds the 64-bit result stable until the pipeline consumes it; feeds the HI/LO write path toward MEM/WB.
- One request in flight; no pipelining of operations.

Parameters:
- DATA_W, 32, operand width; also the iteration count. Only 32 is supported.

Ports:
- clk  in  1  clock (all state on the rising edge)
- resetn  in  1  asynchronous, active-low reset
- md_start  in  1  request; EXE drives EXE_valid & mul_or_div
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with md_start
- md_src1  in  32  multiplicand / dividend; sampled with md_start
- md_src2  in  32  multiplier / divisor; sampled with md_start
- md_ack  in  1  EXE result consumed (EXE->MEM transfer this cycle)
- md_cancel  in  1  flush (exception/eret); highest priority
- md_busy  out  1  state == BUSY
- md_done  out  1  state == DONE; result valid
- md_hi  out  32  MULT: product[63:32]; DIV: remainder
- md_lo  out  32  MULT: product[31:0]; DIV: quotient

Behaviour:
- Reset (async, resetn=0):
  - state = IDLE, counter = 0.
  - md_busy = 0, md_done = 0, md_hi = 0, md_lo = 0.
- States are IDLE, BUSY and DONE. Transition priority, highest first:
  - md_cancel=1 -> IDLE next cycle from any state. md_done/md_busy are 0 from the next cycle on. md_hi/md_lo hold their last value and are don't-care.
  - IDLE: md_start=1 -> BUSY. Operands and op are latched into internal registers; counter = 0.
    - Signed ops convert both operands to magnitudes and record the result signs: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
  - BUSY: one iteration per cycle; counter increments.
    - Multiply: shift-add, one multiplier bit per cycle.
    - Divide: restoring, one quotient bit per cycle.
    - After the 32nd iteration (counter == 31 in that cycle) -> DONE. Sign fix-up and special cases are applied on the transition.
    - md_start is ignored in BUSY.
  - DONE: md_done=1, md_hi/md_lo stable.
    - md_ack=1 -> IDLE.
    - md_ack=0 -> stay in DONE indefinitely (MEM stall); md_start is ignored.
- Latency: start sampled at edge N; BUSY for cycles N+1..N+32; md_done=1 from cycle N+33.
  - Earliest next start is the cycle after the acked DONE cycle.
  - md_ack in any state other than DONE has no effect.
- Arithmetic:
  - MULTU: unsigned 64-bit product.
  - MULT: two's-complement 64-bit product; the result is negated when the product sign is 1.
  - DIVU: unsigned quotient and remainder.
  - DIV: truncating toward zero; remainder takes the dividend sign.
- Special cases:
  - Divide by zero (DIV or DIVU): md_lo = 0xFFFFFFFF, md_hi = md_src1 as latched; no sign fix-up.
  - DIV 0x80000000 / 0xFFFFFFFF: md_lo = 0x80000000, md_hi = 0.
  - The full 32 cycles are always taken; there is no early termination.
- md_start and md_cancel asserted together in IDLE: cancel wins; the block stays IDLE.

Test Plan:
- MULT src1=0xFFFFFFFD, src2=0x00000005 -> md_done at start+33; hi=0xFFFFFFFF, lo=0xFFFFFFF1; md_busy high exactly 32 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo=0x0000000E, hi=0x00000002. DIV -7/2 (0xFFFFFFF9, 0x2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234.
- Hold md_ack=0 for 5 cycles in DONE with md_start held high:
  - md_done stays 1 and results stay stable, no restart.
  - md_ack=1 -> IDLE next cycle; a new start on the following cycle is accepted.
- Mid-operation events:
  - md_cancel at BUSY iteration 10 -> IDLE next cycle, md_busy=0, md_done never asserts.
  - resetn low mid-BUSY -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer for the EXE stage.
//
// Executes MULT, MULTU, DIV and DIVU with one iteration per cycle. There is
// one request in flight at a time. The 64-bit result stays stable in DONE
// until the pipeline consumes it with md_ack.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   resetn     asynchronous, active-low reset
//   md_start   request; md_op, md_src1 and md_src2 are sampled with it in IDLE
//   md_op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   md_src1    multiplicand / dividend
//   md_src2    multiplier / divisor
//   md_ack     result consumed (acts only in DONE)
//   md_cancel  flush; highest priority, returns the block to IDLE
//   md_busy    operation iterating
//   md_done    result valid on md_hi / md_lo
//   md_hi      product[63:32] or remainder
//   md_lo      product[31:0] or quotient
module muldiv_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              md_start,
    input  logic [1:0]        md_op,
    input  logic [DATA_W-1:0] md_src1,
    input  logic [DATA_W-1:0] md_src2,
    input  logic              md_ack,
    input  logic              md_cancel,
    output logic              md_busy,
    output logic              md_done,
    output logic [DATA_W-1:0] md_hi,
    output logic [DATA_W-1:0] md_lo
);

    localparam logic [DATA_W-1:0] ALL_ONES = '1;
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [4:0]        LAST_IT  = 5'd31;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg;
    logic [4:0]        count_reg;
    logic [1:0]        op_reg;
    logic [DATA_W-1:0] src1_reg;       // raw dividend, needed for divide-by-zero
    logic [DATA_W-1:0] src2_reg;       // raw divisor, needed for the overflow case
    logic [DATA_W-1:0] operand_reg;    // multiplicand or divisor magnitude
    logic [DATA_W-1:0] work_hi_reg;    // partial product high half / remainder
    logic [DATA_W-1:0] work_lo_reg;    // multiplier shifter / dividend-quotient shifter
    logic              neg_res_reg;    // product or quotient must be negated
    logic              neg_rem_reg;    // remainder must be negated
    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;

    // Operand magnitudes for the signed forms
    logic              is_signed;
    logic              s1;
    logic              s2;
    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;

    always_comb begin
        is_signed = ~md_op[0];
        s1        = is_signed & md_src1[DATA_W-1];
        s2        = is_signed & md_src2[DATA_W-1];
        mag1      = s1 ? (~md_src1 + 1'b1) : md_src1;
        mag2      = s2 ? (~md_src2 + 1'b1) : md_src2;
    end

    // One iteration step for each operation kind
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   mul_hi;
    logic [DATA_W-1:0]   mul_lo;
    logic [DATA_W:0]     div_trial;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [DATA_W-1:0]   div_hi;
    logic [DATA_W-1:0]   div_lo;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   fin_hi;
    logic [DATA_W-1:0]   fin_lo;

    always_comb begin
        // Shift-add: add multiplicand when the current multiplier bit is set,
        // then shift the {acc, multiplier} pair right by one, carry included.
        mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, operand_reg} : '0);
        mul_hi    = mul_sum[DATA_W:1];
        mul_lo    = {mul_sum[0], work_lo_reg[DATA_W-1:1]};

        // Restoring division: shift next dividend bit into the remainder and
        // subtract the divisor only if it fits. The remainder is always below
        // the divisor, so the kept value fits in DATA_W bits.
        div_trial = {work_hi_reg, work_lo_reg[DATA_W-1]};
        div_ge    = div_trial >= {1'b0, operand_reg};
        div_diff  = div_trial - {1'b0, operand_reg};
        div_hi    = div_ge ? div_diff[DATA_W-1:0] : div_trial[DATA_W-1:0];
        div_lo    = {work_lo_reg[DATA_W-2:0], div_ge};

        // Final result after the last step, with sign fix-up and special cases
        prod      = {mul_hi, mul_lo};
        fin_hi    = '0;
        fin_lo    = '0;
        if (op_reg[1]) begin
            if (src2_reg == '0) begin
                fin_lo = ALL_ONES;
                fin_hi = src1_reg;
            end else if (!op_reg[0] && src1_reg == MIN_NEG && src2_reg == ALL_ONES) begin
                fin_lo = MIN_NEG;
                fin_hi = '0;
            end else begin
                fin_lo = neg_res_reg ? (~div_lo + 1'b1) : div_lo;
                fin_hi = neg_rem_reg ? (~div_hi + 1'b1) : div_hi;
            end
        end else begin
            if (neg_res_reg) begin
                prod = ~prod + 1'b1;
            end
            fin_hi = prod[2*DATA_W-1:DATA_W];
            fin_lo = prod[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            op_reg      <= '0;
            src1_reg    <= '0;
            src2_reg    <= '0;
            operand_reg <= '0;
            work_hi_reg <= '0;
            work_lo_reg <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else if (md_cancel) begin
            // Flush from any state; result registers keep their last value
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (md_start) begin
                        state_reg   <= BUSY;
                        count_reg   <= '0;
                        op_reg      <= md_op;
                        src1_reg    <= md_src1;
                        src2_reg    <= md_src2;
                        neg_res_reg <= s1 ^ s2;
                        neg_rem_reg <= s1;
                        work_hi_reg <= '0;
                        work_lo_reg <= md_op[1] ? mag1 : mag2;
                        operand_reg <= md_op[1] ? mag2 : mag1;
                    end
                end
                BUSY: begin
                    count_reg   <= count_reg + 5'd1;
                    work_hi_reg <= op_reg[1] ? div_hi : mul_hi;
                    work_lo_reg <= op_reg[1] ? div_lo : mul_lo;
                    if (count_reg == LAST_IT) begin
                        state_reg <= DONE;
                        hi_reg    <= fin_hi;
                        lo_reg    <= fin_lo;
                    end
                end
                DONE: begin
                    if (md_ack) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign md_busy = (state_reg == BUSY);
    assign md_done = (state_reg == DONE);
    assign md_hi   = hi_reg;
    assign md_lo   = lo_reg;

endmodule
